hazard_ctrl: RTL

- Pipeline sequencing controller for the IF/ID and ID/IX pipeline registers and the PC.
- Detects load-use hazards, resolves control-flow redirects from IX, and freezes the pipe while data memory is busy.
- Drives write-enable, flush and bubble controls; the ID/IX register zeroes all side-effecting controls (write_to_reg, rw, is_branch, is_jump, is_jal, is_jr) when id_ix_bubble is set.
- Sits beside the decoder; all pipeline registers capture on the same clk edge using these controls.

---
 rtl/hazard_ctrl_if.sv | 38 +++
 rtl/hazard_ctrl.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_if.sv
// Pipeline-sequencing bundle between the decode/execute datapath and hazard_ctrl.
// master = datapath side (drives hazard sources), slave = hazard_ctrl (drives controls).
interface hazard_ctrl_if;
  logic        id_valid;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rs;
  logic        id_uses_rt;
  logic [4:0]  ix_dest;
  logic        ix_is_load;
  logic        ix_write_to_reg;
  logic        ix_redirect;
  logic        dmem_busy;

  logic        pc_we;
  logic        if_id_we;
  logic        id_ix_we;
  logic        if_id_flush;
  logic        id_ix_bubble;
  logic [1:0]  ctrl_state;
  logic        mem_timeout;
  logic [15:0] perf_stalls;
  logic [15:0] perf_flushes;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
           ix_dest, ix_is_load, ix_write_to_reg, ix_redirect, dmem_busy,
    input  pc_we, if_id_we, id_ix_we, if_id_flush, id_ix_bubble,
           ctrl_state, mem_timeout, perf_stalls, perf_flushes
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
           ix_dest, ix_is_load, ix_write_to_reg, ix_redirect, dmem_busy,
    output pc_we, if_id_we, id_ix_we, if_id_flush, id_ix_bubble,
           ctrl_state, mem_timeout, perf_stalls, perf_flushes
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, IX redirect flushes, data-memory freeze.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module hazard_ctrl #(
  parameter int unsigned LOAD_USE_CYCLES = 1,
  parameter int unsigned FLUSH_CYCLES    = 1,
  parameter int unsigned MEM_TIMEOUT     = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    STALL    = 2'd1,
    FLUSH    = 2'd2,
    MEM_WAIT = 2'd3
  } state_t;

  localparam logic [1:0] LU_INIT = 2'(LOAD_USE_CYCLES - 1);
  localparam logic [1:0] FL_INIT = 2'(FLUSH_CYCLES - 1);
  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  state_t     state, state_nx, ret_state, ret_state_nx, eff_state;
  logic [1:0] cnt, cnt_nx;
  logic [7:0] busy_cnt, busy_cnt_nx;
  logic       timeout, timeout_nx;
  logic       rs_hit, rt_hit, lu_hazard;
  logic       pc_we_c, if_id_we_c, id_ix_we_c, flush_c, bubble_c;

  always_comb begin
    rs_hit    = hz.id_uses_rs && (hz.id_rs == hz.ix_dest);
    rt_hit    = hz.id_uses_rt && (hz.id_rt == hz.ix_dest);
    lu_hazard = hz.id_valid && hz.ix_is_load && hz.ix_write_to_reg &&
                (hz.ix_dest != '0) && (rs_hit || rt_hit);
  end

  // On the cycle memory releases, behave as the pre-empted state so the held
  // redirect/hazard is acted on without losing a cycle.
  assign eff_state = (state == MEM_WAIT && !hz.dmem_busy) ? ret_state : state;

  always_comb begin
    state_nx     = eff_state;
    ret_state_nx = ret_state;
    cnt_nx       = cnt;
    busy_cnt_nx  = busy_cnt;
    timeout_nx   = timeout;
    pc_we_c      = 1'b1;
    if_id_we_c   = 1'b1;
    id_ix_we_c   = 1'b1;
    flush_c      = 1'b0;
    bubble_c     = 1'b0;

    if (state == MEM_WAIT && !hz.dmem_busy)
      busy_cnt_nx = '0;

    if (hz.dmem_busy && state != FLUSH) begin
      pc_we_c    = 1'b0;
      if_id_we_c = 1'b0;
      id_ix_we_c = 1'b0;
      state_nx   = MEM_WAIT;
      if (state != MEM_WAIT) begin
        ret_state_nx = state;
        busy_cnt_nx  = 8'd1;
      end else if (busy_cnt != '1) begin
        busy_cnt_nx = busy_cnt + 8'd1;
      end
      if (busy_cnt_nx >= TIMEOUT)
        timeout_nx = 1'b1;
    end else begin
      case (eff_state)
        RUN: begin
          if (hz.ix_redirect) begin
            flush_c  = 1'b1;
            bubble_c = 1'b1;
            cnt_nx   = FL_INIT;
            state_nx = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
          end else if (lu_hazard) begin
            pc_we_c    = 1'b0;
            if_id_we_c = 1'b0;
            bubble_c   = 1'b1;
            cnt_nx     = LU_INIT;
            state_nx   = (LOAD_USE_CYCLES > 1) ? STALL : RUN;
          end
        end
        STALL: begin
          pc_we_c    = 1'b0;
          if_id_we_c = 1'b0;
          bubble_c   = 1'b1;
          cnt_nx     = cnt - 2'd1;
          state_nx   = (cnt <= 2'd1) ? RUN : STALL;
        end
        FLUSH: begin
          flush_c  = 1'b1;
          bubble_c = 1'b1;
          cnt_nx   = cnt - 2'd1;
          state_nx = (cnt <= 2'd1) ? RUN : FLUSH;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      ret_state <= RUN;
      cnt       <= '0;
      busy_cnt  <= '0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nx;
      ret_state <= ret_state_nx;
      cnt       <= cnt_nx;
      busy_cnt  <= busy_cnt_nx;
      timeout   <= timeout_nx;
    end
  end

  // Reset overrides the controls combinationally so the pipe is held the instant rst_n drops.
  assign hz.pc_we        = rst_n & pc_we_c;
  assign hz.if_id_we     = rst_n & if_id_we_c;
  assign hz.id_ix_we     = rst_n & id_ix_we_c;
  assign hz.if_id_flush  = ~rst_n | flush_c;
  assign hz.id_ix_bubble = ~rst_n | bubble_c;
  assign hz.ctrl_state   = state;
  assign hz.mem_timeout  = timeout;

`ifdef HAZARD_PERF_EN
  logic [15:0] stalls, flushes;
  logic        redirect_acc;

  assign redirect_acc = (eff_state == RUN) && !hz.dmem_busy && hz.ix_redirect;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stalls  <= '0;
      flushes <= '0;
    end else begin
      if (!pc_we_c && stalls != '1)
        stalls <= stalls + 16'd1;
      if (redirect_acc && flushes != '1)
        flushes <= flushes + 16'd1;
    end
  end

  assign hz.perf_stalls  = stalls;
  assign hz.perf_flushes = flushes;
`else
  assign hz.perf_stalls  = '0;
  assign hz.perf_flushes = '0;
`endif

endmodule
